// File: rtl/riscv_pkg.sv
// Shared execute-stage types and constants for the iterative multiplier.
// Holds the RV32M multiply op encoding and the multiplier FSM state encoding.
package riscv_pkg;

    localparam int MUL_NB_BITS = 32;
    localparam int MUL_CNT_W   = $clog2(MUL_NB_BITS);

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        NEG  = 2'b10,
        DONE = 2'b11
    } mul_state_t;

endpackage

// File: rtl/adder_n_bits.sv
// Purpose: nb_bits-wide ripple-style adder with carry in and carry out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module adder_n_bits #(
    parameter int nb_bits = 32
) (
    input  logic [nb_bits-1:0] a_i,
    input  logic [nb_bits-1:0] b_i,
    input  logic               cin_i,
    output logic [nb_bits-1:0] sum_o,
    output logic               cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{nb_bits{1'b0}}, cin_i};

endmodule

// File: rtl/mul_iterative.sv
// Purpose: radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Latency: result valid nb_bits+1 edges after accept; one request in flight at a time.
// Backpressure: in_ready_o only in IDLE; result held in DONE until out_ready_i, abort_i cancels.
module mul_iterative
    import riscv_pkg::*;
#(
    parameter int nb_bits = MUL_NB_BITS
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [1:0]         op_i,
    input  logic [nb_bits-1:0] rs1_i,
    input  logic [nb_bits-1:0] rs2_i,
    input  logic               abort_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [nb_bits-1:0] result_o
);

    localparam int CNT_W = $clog2(nb_bits);

    mul_state_t               state_q, state_d;
    mul_op_t                  op_q, op_w;
    logic                     neg_q;
    logic [nb_bits-1:0]       mcand_q, mplier_q, acc_hi_q;
    logic [CNT_W-1:0]         cnt_q;

    logic                     accept_w;
    logic                     rs1_neg_w, rs2_neg_w;
    logic [nb_bits-1:0]       rs1_mag_w, rs2_mag_w;
    logic [nb_bits-1:0]       add_b_w, add_sum_w;
    logic                     add_cout_w;
    logic [2*nb_bits-1:0]     prod_w, prod_neg_w;

    assign op_w = mul_op_t'(op_i);

    // Only signed operands contribute a sign; the most negative value stays as its unsigned magnitude.
    assign rs1_neg_w = ((op_w == MULH) || (op_w == MULHSU)) && rs1_i[nb_bits-1];
    assign rs2_neg_w = (op_w == MULH) && rs2_i[nb_bits-1];
    assign rs1_mag_w = rs1_neg_w ? -rs1_i : rs1_i;
    assign rs2_mag_w = rs2_neg_w ? -rs2_i : rs2_i;

    assign add_b_w    = mplier_q[0] ? mcand_q : '0;
    assign prod_w     = {acc_hi_q, mplier_q};
    assign prod_neg_w = -prod_w;

    adder_n_bits #(.nb_bits(nb_bits)) u_adder (
        .a_i    (acc_hi_q),
        .b_i    (add_b_w),
        .cin_i  (1'b0),
        .sum_o  (add_sum_w),
        .cout_o (add_cout_w)
    );

    always_comb begin
        state_d     = state_q;
        accept_w    = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        result_o    = '0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (!abort_i && in_valid_i) begin
                    accept_w = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (abort_i)
                    state_d = IDLE;
                else if (cnt_q == CNT_W'(nb_bits - 1))
                    state_d = NEG;
            end
            NEG: state_d = abort_i ? IDLE : DONE;
            DONE: begin
                out_valid_o = 1'b1;
                result_o    = (op_q == MUL) ? mplier_q : acc_hi_q;
                if (abort_i || out_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept_w) begin
                op_q     <= op_w;
                neg_q    <= (op_w != MUL) && (rs1_neg_w ^ rs2_neg_w);
                mcand_q  <= rs1_mag_w;
                mplier_q <= rs2_mag_w;
                acc_hi_q <= '0;
                cnt_q    <= '0;
            end else if (state_q == BUSY && !abort_i) begin
                acc_hi_q <= {add_cout_w, add_sum_w[nb_bits-1:1]};
                mplier_q <= {add_sum_w[0], mplier_q[nb_bits-1:1]};
                cnt_q    <= cnt_q + CNT_W'(1);
            end else if (state_q == NEG && !abort_i && neg_q) begin
                {acc_hi_q, mplier_q} <= prod_neg_w;
            end
        end
    end

endmodule

// File: tb/tb_mul_iterative.sv
// Self-checking bench for mul_iterative: directed table, handshake/abort/reset corners, random ops vs a 64-bit model.
module tb_mul_iterative;

    logic        clk_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        abort_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mul_iterative #(.nb_bits(32)) dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .abort_i     (abort_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits by its signedness; the low 64 bits of that product are exact.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one request from IDLE and wait for out_valid_o; lat is edges after accept, -1 on timeout.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk_i);
        op_i = op; rs1_i = a; rs2_i = b; in_valid_i = 1'b1;
        @(posedge clk_i);
        lat = -1;
        res = '0;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk_i);
            in_valid_i = 1'b0;
            if (out_valid_o) begin
                lat = n;
                res = result_o;
                break;
            end
        end
        if (lat < 0) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check("idle_after_consume_valid", {31'b0, out_valid_o}, 32'd0);
        check("idle_after_consume_ready", {31'b0, in_ready_o}, 32'd1);
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int lat;
        issue(op, a, b, res, lat);
        check(name, res, exp);
        check({name, "_lat"}, lat, 32'd33);
        consume();
    endtask

    initial begin
        vec_t vecs[7];
        logic [31:0] res, held;
        int lat;
        bit seen;

        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [31:0] res, held;
        int lat;
        bit seen;

        vecs[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3] = '{2'b01, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFFF};
        vecs[4] = '{2'b00, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFF1};
        vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6] = '{2'b11, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};

        // Reset state
        #12;
        check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk_i);
        resetn_i = 1'b1;

        // Directed vectors
        for (int i = 0; i < 7; i++)
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Hold result under backpressure, then present a request in DONE alongside out_ready_i
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, res, lat);
        check("hold_lat", lat, 32'd33);
        held = res;
        check("hold_value", held, ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("hold_stable", result_o, held);
            check("hold_valid", {31'b0, out_valid_o}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready_o}, 32'd0);
        end
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        op_i = 2'b11; rs1_i = 32'd7; rs2_i = 32'd9;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        check("done_req_not_taken", {31'b0, in_ready_o}, 32'd1);
        check("done_req_no_valid", {31'b0, out_valid_o}, 32'd0);

        // abort_i in IDLE wins over accept
        in_valid_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        abort_i = 1'b0;
        check("idle_abort_ready", {31'b0, in_ready_o}, 32'd1);

        // abort_i during iteration 10
        @(negedge clk_i);
        op_i = 2'b11; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'hCAFE_F00D; in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_ready", {31'b0, in_ready_o}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (out_valid_o) seen = 1'b1;
        end
        check("abort_no_valid", {31'b0, seen}, 32'd0);
        run_one("after_abort", 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, ref_mul(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D));

        // Asynchronous reset mid-BUSY
        @(negedge clk_i);
        op_i = 2'b01; rs1_i = 32'h8765_4321; rs2_i = 32'h1357_9BDF; in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("busy_not_ready", {31'b0, in_ready_o}, 32'd0);
        #2 resetn_i = 1'b0;
        #1;
        check("arst_in_ready", {31'b0, in_ready_o}, 32'd1);
        check("arst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        @(negedge clk_i);
        resetn_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (out_valid_o) seen = 1'b1;
        end
        check("arst_no_valid", {31'b0, seen}, 32'd0);

        // Random ops, with corner operand values mixed in
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'h0000_0000;
                default: ;
            endcase
            run_one($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_mul(op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
